// File: rtl/aes128_round_primitives.sv
// AES-128 encryption primitives: sequential key schedule, registered full round, registered final round.
// Top level exposes the key schedule, one standalone round and last round, and a 10-stage cipher pipeline.
package aes128_pkg;

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[11'd2047 - {x, 3'b000} -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = sbox(s[8*i +: 8]);
    return r;
  endfunction

  // Row r of column c takes the byte from column (c+r) mod 4.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int c = 0; c < 4; c++)
      for (int w = 0; w < 4; w++)
        r[127 - 8*(4*c + w) -: 8] = s[127 - 8*(4*((c + w) % 4) + w) -: 8];
    return r;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0]   a0, a1, a2, a3;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127 - 32*c -: 8];
      a1 = s[119 - 32*c -: 8];
      a2 = s[111 - 32*c -: 8];
      a3 = s[103 - 32*c -: 8];
      r[127 - 32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      r[119 - 32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      r[111 - 32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      r[103 - 32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return r;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    logic [7:0] r;
    case (i)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  function automatic logic [127:0] key_step(input logic [127:0] w, input logic [7:0] rc);
    logic [31:0] n0, n1, n2, n3;
    n0 = w[127:96] ^ sub_word({w[23:0], w[31:24]}) ^ {rc, 24'h0};
    n1 = w[95:64] ^ n0;
    n2 = w[63:32] ^ n1;
    n3 = w[31:0] ^ n2;
    return {n0, n1, n2, n3};
  endfunction

endpackage

module keyexpansion (
  input  logic          clk,
  input  logic          rst,
  input  logic [127:0]  key,
  input  logic          start,
  output logic [1407:0] out,
  output logic          finish
);
  import aes128_pkg::*;

  logic [3:0]   idx_q;
  logic [127:0] rk_q [0:10];
  logic         finish_q;
  logic [127:0] prev_d;
  logic [127:0] next_d;

  always_comb begin
    prev_d = '0;
    for (int i = 1; i <= 10; i++)
      if (idx_q == 4'(i)) prev_d = rk_q[i-1];
  end

  assign next_d = key_step(prev_d, rcon(idx_q));

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q    <= 4'd0;
      finish_q <= 1'b0;
      for (int i = 0; i <= 10; i++) rk_q[i] <= '0;
    end else if (start && idx_q == 4'd0) begin
      rk_q[0] <= key;
      idx_q   <= 4'd1;
    end else if (start && idx_q >= 4'd1 && idx_q <= 4'd10) begin
      for (int i = 1; i <= 10; i++)
        if (idx_q == 4'(i)) rk_q[i] <= next_d;
      idx_q <= idx_q + 4'd1;
      if (idx_q == 4'd10) finish_q <= 1'b1;
    end
  end

  for (genvar g = 0; g <= 10; g++) begin : g_out
    assign out[1407 - 128*g -: 128] = rk_q[g];
  end

  assign finish = finish_q;
endmodule

module round (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] key,
  input  logic [127:0] state,
  output logic [127:0] out
);
  import aes128_pkg::*;

  logic [127:0] out_q;

  always_ff @(posedge clk) begin
    if (rst) out_q <= '0;
    else     out_q <= mix_columns(shift_rows(sub_bytes(state))) ^ key;
  end

  assign out = out_q;
endmodule

module lastround (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] key,
  input  logic [127:0] state,
  output logic [127:0] out
);
  import aes128_pkg::*;

  logic [127:0] out_q;

  always_ff @(posedge clk) begin
    if (rst) out_q <= '0;
    else     out_q <= shift_rows(sub_bytes(state)) ^ key;
  end

  assign out = out_q;
endmodule

module aes128_round_primitives (
  input  logic          clk,
  input  logic          rst,
  input  logic [127:0]  key_i,
  input  logic          start_i,
  output logic [1407:0] rk_o,
  output logic          finish_o,
  input  logic [127:0]  rnd_key_i,
  input  logic [127:0]  rnd_state_i,
  output logic [127:0]  rnd_out_o,
  input  logic [127:0]  lr_key_i,
  input  logic [127:0]  lr_state_i,
  output logic [127:0]  lr_out_o,
  input  logic [127:0]  pt_i,
  output logic [127:0]  ct_o
);
  logic [127:0] stage [0:10];

  keyexpansion u_kexp (
    .clk(clk), .rst(rst), .key(key_i), .start(start_i), .out(rk_o), .finish(finish_o)
  );

  round u_round (
    .clk(clk), .rst(rst), .key(rnd_key_i), .state(rnd_state_i), .out(rnd_out_o)
  );

  lastround u_lastround (
    .clk(clk), .rst(rst), .key(lr_key_i), .state(lr_state_i), .out(lr_out_o)
  );

  // Cipher pipeline: whitening with RK0, nine full rounds, one final round.
  assign stage[0] = pt_i ^ rk_o[1407 -: 128];

  for (genvar g = 1; g <= 9; g++) begin : g_chain
    round u_r (
      .clk(clk), .rst(rst), .key(rk_o[1407 - 128*g -: 128]), .state(stage[g-1]), .out(stage[g])
    );
  end

  lastround u_lr (
    .clk(clk), .rst(rst), .key(rk_o[127:0]), .state(stage[9]), .out(stage[10])
  );

  assign ct_o = stage[10];
endmodule

// File: tb/tb_aes128_round_primitives.sv
// Bench for the AES-128 primitives against a byte-level reference built from GF(2^8) arithmetic.
module tb_aes128_round_primitives;
  logic          clk = 1'b0;
  logic          rst;
  logic [127:0]  key_i;
  logic          start_i;
  logic [1407:0] rk_o;
  logic          finish_o;
  logic [127:0]  rnd_key_i, rnd_state_i, rnd_out_o;
  logic [127:0]  lr_key_i, lr_state_i, lr_out_o;
  logic [127:0]  pt_i, ct_o;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  logic [7:0]   sb_m [0:255];
  logic [127:0] m_rk [0:10];
  logic [127:0] exp_ct [0:19];

  always #5 clk = ~clk;

  aes128_round_primitives dut (
    .clk(clk), .rst(rst), .key_i(key_i), .start_i(start_i), .rk_o(rk_o), .finish_o(finish_o),
    .rnd_key_i(rnd_key_i), .rnd_state_i(rnd_state_i), .rnd_out_o(rnd_out_o),
    .lr_key_i(lr_key_i), .lr_state_i(lr_state_i), .lr_out_o(lr_out_o),
    .pt_i(pt_i), .ct_o(ct_o)
  );

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  // S-box from its definition: multiplicative inverse followed by the affine map.
  function automatic logic [7:0] calc_sbox(input logic [7:0] x);
    logic [7:0] inv;
    inv = 8'h00;
    if (x != 8'h00) begin
      inv = 8'h01;
      for (int i = 0; i < 254; i++) inv = gmul(inv, x);
    end
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [127:0] m_round(input logic [127:0] s, input logic [127:0] k, input bit mix);
    logic [7:0]   a [16];
    logic [7:0]   b [16];
    logic [7:0]   v;
    logic [7:0]   coef;
    logic [127:0] r;
    for (int i = 0; i < 16; i++) a[i] = sb_m[s[127 - 8*i -: 8]];
    for (int c = 0; c < 4; c++)
      for (int w = 0; w < 4; w++) b[4*c + w] = a[4*((c + w) % 4) + w];
    if (mix) begin
      for (int c = 0; c < 4; c++)
        for (int w = 0; w < 4; w++) begin
          v = 8'h00;
          for (int j = 0; j < 4; j++) begin
            coef = ((j - w + 4) % 4 == 0) ? 8'h02 : ((j - w + 4) % 4 == 1) ? 8'h03 : 8'h01;
            v = v ^ gmul(coef, b[4*c + j]);
          end
          a[4*c + w] = v;
        end
    end else begin
      for (int i = 0; i < 16; i++) a[i] = b[i];
    end
    r = '0;
    for (int i = 0; i < 16; i++) r[127 - 8*i -: 8] = a[i];
    return r ^ k;
  endfunction

  // Word-oriented schedule over w[0..43].
  task automatic m_expand(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sb_m[t[23:16]], sb_m[t[15:8]], sb_m[t[7:0]], sb_m[t[31:24]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++) m_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] m_encrypt(input logic [127:0] pt);
    logic [127:0] s;
    s = pt ^ m_rk[0];
    for (int r = 1; r <= 9; r++) s = m_round(s, m_rk[r], 1'b1);
    return m_round(s, m_rk[10], 1'b0);
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start_i = 1'b0; key_i = rnd128();
    rnd_key_i = rnd128(); rnd_state_i = rnd128();
    lr_key_i = rnd128(); lr_state_i = rnd128(); pt_i = rnd128();
    tick();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    rnd_state_i = rnd128() | 128'h1; lr_state_i = rnd128() | 128'h1;
    tick();
    chk_cnt++;
    if (rnd_out_o !== 128'h0) $display("FAIL reset_round: got %h want 0", rnd_out_o);
    else pass_cnt++;
    chk_cnt++;
    if (lr_out_o !== 128'h0) $display("FAIL reset_lastround: got %h want 0", lr_out_o);
    else pass_cnt++;
    chk_cnt++;
    if (ct_o !== 128'h0) $display("FAIL reset_chain: got %h want 0", ct_o);
    else pass_cnt++;
    chk_cnt++;
    if (|rk_o !== 1'b0) $display("FAIL reset_rk: got any-bit-set %b want 0", |rk_o);
    else pass_cnt++;
    chk_cnt++;
    if (finish_o !== 1'b0) $display("FAIL reset_finish: got %b want 0", finish_o);
    else pass_cnt++;
  endtask

  task automatic test_keyexp();
    logic [127:0] k;
    k = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    m_expand(k);
    rst = 1'b1; tick();
    rst = 1'b0; start_i = 1'b1; key_i = k;
    for (int e = 1; e <= 11; e++) begin
      tick();
      if (e == 1) begin
        chk_cnt++;
        if (rk_o[1407 -: 128] !== k) $display("FAIL kexp_rk0_edge1: got %h want %h", rk_o[1407 -: 128], k);
        else pass_cnt++;
      end
      chk_cnt++;
      if (finish_o !== (e == 11)) $display("FAIL kexp_finish_edge%0d: got %b want %b", e, finish_o, e == 11);
      else pass_cnt++;
    end
    chk_cnt++;
    if (rk_o[1279 -: 128] !== 128'ha0fafe1788542cb123a339392a6c7605)
      $display("FAIL kexp_rk1_vector: got %h want a0fafe1788542cb123a339392a6c7605", rk_o[1279 -: 128]);
    else pass_cnt++;
    chk_cnt++;
    if (rk_o[127:0] !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6)
      $display("FAIL kexp_rk10_vector: got %h want d014f9a8c9ee2589e13f0cc8b6630ca6", rk_o[127:0]);
    else pass_cnt++;
    for (int r = 0; r <= 10; r++) begin
      chk_cnt++;
      if (rk_o[1407 - 128*r -: 128] !== m_rk[r])
        $display("FAIL kexp_rk%0d_model: got %h want %h", r, rk_o[1407 - 128*r -: 128], m_rk[r]);
      else pass_cnt++;
    end
    key_i = rnd128();
    tick(); tick(); tick();
    chk_cnt++;
    if (finish_o !== 1'b1) $display("FAIL kexp_finish_hold: got %b want 1", finish_o);
    else pass_cnt++;
    chk_cnt++;
    if (rk_o[1407 -: 128] !== k) $display("FAIL kexp_key_ignored: got %h want %h", rk_o[1407 -: 128], k);
    else pass_cnt++;
    chk_cnt++;
    if (rk_o[127:0] !== m_rk[10]) $display("FAIL kexp_rk10_hold: got %h want %h", rk_o[127:0], m_rk[10]);
    else pass_cnt++;
  endtask

  task automatic test_pause();
    rst = 1'b1; tick();
    rst = 1'b0; key_i = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    m_expand(key_i);
    for (int e = 1; e <= 14; e++) begin
      start_i = !(e >= 6 && e <= 8);
      tick();
      if (e == 8) begin
        chk_cnt++;
        if (rk_o[1407 - 128*5 -: 128] !== 128'h0)
          $display("FAIL pause_rk5_frozen: got %h want 0", rk_o[1407 - 128*5 -: 128]);
        else pass_cnt++;
      end
      chk_cnt++;
      if (finish_o !== (e >= 14)) $display("FAIL pause_finish_edge%0d: got %b want %b", e, finish_o, e >= 14);
      else pass_cnt++;
    end
    chk_cnt++;
    if (rk_o[127:0] !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6)
      $display("FAIL pause_rk10: got %h want d014f9a8c9ee2589e13f0cc8b6630ca6", rk_o[127:0]);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    rst = 1'b1; tick();
    rst = 1'b0; start_i = 1'b1; key_i = rnd128();
    for (int e = 1; e <= 6; e++) tick();
    rst = 1'b1;
    tick();
    chk_cnt++;
    if (|rk_o !== 1'b0) $display("FAIL midrst_rk: got any-bit-set %b want 0", |rk_o);
    else pass_cnt++;
    chk_cnt++;
    if (finish_o !== 1'b0) $display("FAIL midrst_finish: got %b want 0", finish_o);
    else pass_cnt++;
    rst = 1'b0; key_i = rnd128();
    m_expand(key_i);
    for (int e = 1; e <= 11; e++) tick();
    chk_cnt++;
    if (finish_o !== 1'b1) $display("FAIL midrst_refinish: got %b want 1", finish_o);
    else pass_cnt++;
    for (int r = 0; r <= 10; r++) begin
      chk_cnt++;
      if (rk_o[1407 - 128*r -: 128] !== m_rk[r])
        $display("FAIL midrst_rk%0d: got %h want %h", r, rk_o[1407 - 128*r -: 128], m_rk[r]);
      else pass_cnt++;
    end
  endtask

  task automatic test_rounds();
    logic [127:0] want_r, want_l;
    rnd_state_i = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    rnd_key_i   = 128'ha0fafe1788542cb123a339392a6c7605;
    lr_state_i  = 128'heb40f21e592e38848ba113e71bc342d2;
    lr_key_i    = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    tick();
    chk_cnt++;
    if (rnd_out_o !== 128'ha49c7ff2689f352b6b5bea43026a5049)
      $display("FAIL round_vector: got %h want a49c7ff2689f352b6b5bea43026a5049", rnd_out_o);
    else pass_cnt++;
    chk_cnt++;
    if (lr_out_o !== 128'h3925841d02dc09fbdc118597196a0b32)
      $display("FAIL lastround_vector: got %h want 3925841d02dc09fbdc118597196a0b32", lr_out_o);
    else pass_cnt++;
    for (int n = 0; n < 20; n++) begin
      rnd_state_i = rnd128(); rnd_key_i = rnd128();
      lr_state_i  = rnd128(); lr_key_i  = rnd128();
      want_r = m_round(rnd_state_i, rnd_key_i, 1'b1);
      want_l = m_round(lr_state_i, lr_key_i, 1'b0);
      tick();
      chk_cnt++;
      if (rnd_out_o !== want_r) $display("FAIL round_rand%0d: got %h want %h", n, rnd_out_o, want_r);
      else pass_cnt++;
      chk_cnt++;
      if (lr_out_o !== want_l) $display("FAIL lastround_rand%0d: got %h want %h", n, lr_out_o, want_l);
      else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back();
    rst = 1'b1; tick();
    rst = 1'b0; start_i = 1'b1; key_i = 128'h000102030405060708090a0b0c0d0e0f;
    m_expand(key_i);
    for (int e = 1; e <= 11; e++) tick();
    chk_cnt++;
    if (finish_o !== 1'b1) $display("FAIL chain_keys_ready: got %b want 1", finish_o);
    else pass_cnt++;
    for (int t = 0; t <= 28; t++) begin
      pt_i = (t == 0) ? 128'h00112233445566778899aabbccddeeff : rnd128();
      if (t < 20) exp_ct[t] = m_encrypt(pt_i);
      tick();
      if (t == 9) begin
        chk_cnt++;
        if (ct_o !== 128'h69c4e0d86a7b0430d8cdb78070b4c55a)
          $display("FAIL chain_fips_vector: got %h want 69c4e0d86a7b0430d8cdb78070b4c55a", ct_o);
        else pass_cnt++;
      end
      if (t >= 9) begin
        chk_cnt++;
        if (ct_o !== exp_ct[t-9]) $display("FAIL chain_block%0d: got %h want %h", t - 9, ct_o, exp_ct[t-9]);
        else pass_cnt++;
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) sb_m[i] = calc_sbox(8'(i));
    test_reset();
    test_keyexp();
    test_pause();
    test_reset_mid();
    test_rounds();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule

// File: doc/aes128_round_primitives.md
# aes128_round_primitives

Three AES-128 encryption building blocks, implemented as three modules: `keyexpansion`, `round` and `lastround`.
- `keyexpansion` sequentially derives all 11 round keys from a 128-bit cipher key.
- `round` is one registered full AES round.
- `lastround` is one registered final round, without MixColumns.

The parent encryption engine chains nine `round` instances and one `lastround` instance into an 10-stage pipeline, fed from the `keyexpansion` output bus.

## Interface
Parameters: none.

Clocking and reset for all three modules: reset rst, synchronous, active-high; clock clk.

`keyexpansion` ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous active-high reset
- key  in  128  cipher key, FIPS-197 byte order (bits 127:120 = byte 0)
- start  in  1  enable; expansion advances only while high
- out  out  1408  round keys 0..10 concatenated; RK0 = out[1407:1280], RKi = out[1407-128i -: 128], RK10 = out[127:0]
- finish  out  1  high once all 11 round keys are valid

`round` / `lastround` ports:
- clk  in  1  clock (the parent may gate it)
- rst  in  1  synchronous active-high reset
- key  in  128  round key
- state  in  128  input state, column-major (bits 127:120 = s[0,0], 119:112 = s[1,0], …)
- out  out  128  registered result

## Operation
- Byte and bit order follow FIPS-197 throughout. Column c is bits [127-32c -: 32], with row 0 in the MSB byte.
- `round`: on each posedge, out <= MixColumns(ShiftRows(SubBytes(state))) ^ key.
  - SubBytes uses the standard AES S-box: 16 combinational instances, by ROM or case table.
  - MixColumns is over GF(2^8) with polynomial 0x11B and matrix rows [2 3 1 1], rotated.
- `lastround`: out <= ShiftRows(SubBytes(state)) ^ key. No MixColumns.
- `keyexpansion` uses an internal index register idx, 0..11, plus an out register array.
  - If rst: idx <= 0, out <= 0, finish <= 0. rst has priority over everything.
  - Else if start && idx==0: RK0 <= key; idx <= 1.
  - Else if start && 1<=idx<=10:
    - RK[idx] <= g(RK[idx-1], Rcon[idx]); idx <= idx+1.
    - When idx==10, also finish <= 1.
  - Else: hold all state.
  - g is the standard AES-128 schedule:
    - w0' = w0 ^ SubWord(RotWord(w3)) ^ {Rcon,0,0,0}
    - w1' = w1 ^ w0'
    - w2' = w2 ^ w1'
    - w3' = w3 ^ w2'
  - Rcon[1..10] = 01 02 04 08 10 20 40 80 1b 36.
- `key` is sampled only at the idx==0 load. Later changes are ignored until the next rst.
- finish stays high, and out stays stable, until rst.
- start dropping mid-expansion pauses the expansion. It resumes from the same idx when start returns high.

## Timing
- Reset values: `round`/`lastround` out = 0; `keyexpansion` out = 0, finish = 0.
- `round`/`lastround`: 1-cycle latency, fully pipelined, accepting a new state every enabled clock. out is stable while the clock is gated.
- `keyexpansion` with start held high from the first cycle after reset:
  - RK0 is valid after edge 1.
  - RKi is valid after edge i+1.
  - RK10 and finish both become valid after edge 11: 11 enabled cycles in total.
- rst asserted mid-expansion: on the next edge the block returns to idx 0 with out and finish cleared. A fresh expansion then restarts.
- Partial round keys on out are visible before finish. Consumers must qualify with finish.

## Test plan
- Key expansion:
  - Stimulus: rst, then key = 2b7e151628aed2a6abf7158809cf4f3c with start=1.
  - Required: finish rises after edge 11; RK0 = key; RK1 = a0fafe1788542cb123a339392a6c7605; RK10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
- Pause and reset:
  - Stimulus: drop start after edge 5 for 3 cycles, then raise it again.
  - Required: finish after edge 14 with the same RK10.
  - Stimulus: rst asserted at edge 7.
  - Required: out = 0 and finish = 0 on the next edge.
- `round`:
  - Stimulus: state = 193de3bea0f4e22b9ac68d2ae9f84808, key = RK1.
  - Required: after 1 edge, out = a49c7ff2689f352b6b5bea43026a5049.
- `lastround`:
  - Stimulus: state = eb40f21e592e38848ba113e71bc342d2, key = RK10.
  - Required: out = 3925841d02dc09fbdc118597196a0b32.
- Full chain:
  - Stimulus: key 000102030405060708090a0b0c0d0e0f; plaintext 00112233445566778899aabbccddeeff XOR RK0 fed into 9 `round` + 1 `lastround`.
  - Required: 69c4e0d86a7b0430d8cdb78070b4c55a appears 10 cycles later. Back-to-back blocks emerge on consecutive cycles.
- Reset: rst asserted with nonzero state → all `round` and `lastround` outputs = 0 on the next edge.
